// File: rtl/core_pkg.sv
// core_pkg: shared state encoding, opcode width and strobe bundle
// for the 8-bit core sequencer.
package core_pkg;

  localparam int OPC_W = 4;
  localparam logic [OPC_W-1:0] HALT_OPC_DEF = 4'hF;

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_FETCH  = 3'd1,
    S_DECODE = 3'd2,
    S_EXEC   = 3'd3,
    S_MEM    = 3'd4,
    S_WB     = 3'd5,
    S_PAUSE  = 3'd6,
    S_HALT   = 3'd7
  } state_e;

  typedef struct packed {
    logic ir_load;
    logic rf_we;
    logic mem_req;
    logic mem_we;
    logic pc_en;
    logic pc_load;
  } strobe_t;

endpackage

// File: rtl/core_sequencer_if.sv
// core_sequencer_if: data-RAM request/ready handshake between the
// sequencer (master) and the RAM (slave).
interface core_sequencer_if;

  logic mem_req;
  logic mem_we;
  logic mem_ready;

  modport master (
    output mem_req,
    output mem_we,
    input  mem_ready
  );

  modport slave (
    input  mem_req,
    input  mem_we,
    output mem_ready
  );

endinterface

// File: rtl/seq_wait_timer.sv
// seq_wait_timer: RAM wait counter; expired_o flags the last
// allowed wait cycle while counting.
module seq_wait_timer #(
  parameter int TO_W        = 4,
  parameter int MEM_TIMEOUT = 8
) (
  input  logic clk,
  input  logic reset,
  input  logic clr_i,
  input  logic en_i,
  output logic expired_o
);

  logic [TO_W-1:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (clr_i) begin
      cnt_d = '0;
    end else if (en_i) begin
      cnt_d = cnt_q + 1'b1;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign expired_o = en_i &&
    (cnt_q == TO_W'(MEM_TIMEOUT - 1));

endmodule

// File: rtl/core_sequencer.sv
// core_sequencer: multi-cycle control FSM for the 8-bit core.
// Define SEQ_PERF_CNT_EN to add cycle_cnt/instr_cnt counters.
module core_sequencer
  import core_pkg::*;
#(
  parameter logic [OPC_W-1:0] HALT_OPCODE = HALT_OPC_DEF,
  parameter int MEM_TIMEOUT = 8,
  parameter int TO_W        = 4
`ifdef SEQ_PERF_CNT_EN
  ,
  parameter int CNT_W       = 16
`endif
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic             step_mode,
  input  logic             step,
  input  logic             halt_req,
  input  logic             fault_clr,
  input  logic [OPC_W-1:0] opcode,
  input  logic             dec_reg_write,
  input  logic             dec_mem_write,
  input  logic             dec_load,
  input  logic             dec_branch,
  input  logic             zero,
  core_sequencer_if.master mem,
  output logic             ir_load,
  output logic             rf_we,
  output logic             pc_en,
  output logic             pc_load,
  output logic             busy,
  output logic             halted,
  output logic             fault,
`ifdef SEQ_PERF_CNT_EN
  output logic [CNT_W-1:0] cycle_cnt,
  output logic [CNT_W-1:0] instr_cnt,
`endif
  output logic [2:0]       state_o
);

  state_e  state_q, state_d;
  logic    fault_q, fault_d;
  logic    zero_q, zero_d;
  logic    in_mem, tmr_clr, tmr_exp;
  strobe_t strb;

  // FAULT parks the state register in IDLE; fault_q gates it.
  assign in_mem  = !fault_q && (state_q == S_MEM);
  assign tmr_clr = in_mem && (mem.mem_ready || tmr_exp);

  seq_wait_timer #(
    .TO_W        (TO_W),
    .MEM_TIMEOUT (MEM_TIMEOUT)
  ) u_tmr (
    .clk       (clk),
    .reset     (reset),
    .clr_i     (tmr_clr),
    .en_i      (in_mem),
    .expired_o (tmr_exp)
  );

  always_comb begin
    state_d = state_q;
    fault_d = fault_q;
    zero_d  = zero_q;
    if (fault_q) begin
      if (fault_clr) fault_d = 1'b0;
    end else begin
      unique case (state_q)
        S_IDLE:   if (start) state_d = S_FETCH;
        S_FETCH:  state_d = S_DECODE;
        S_DECODE: state_d = (opcode == HALT_OPCODE) ?
                            S_HALT : S_EXEC;
        S_EXEC: begin
          zero_d  = zero;
          state_d = (dec_mem_write || dec_load) ?
                    S_MEM : S_WB;
        end
        S_MEM: begin
          if (mem.mem_ready) begin
            state_d = S_WB;
          end else if (tmr_exp) begin
            state_d = S_IDLE;
            fault_d = 1'b1;
          end
        end
        S_WB: begin
          if (halt_req)       state_d = S_HALT;
          else if (step_mode) state_d = S_PAUSE;
          else                state_d = S_FETCH;
        end
        S_PAUSE: begin
          if (halt_req)  state_d = S_HALT;
          else if (step) state_d = S_FETCH;
        end
        S_HALT:   if (start) state_d = S_FETCH;
      endcase
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= S_IDLE;
      fault_q <= 1'b0;
      zero_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      fault_q <= fault_d;
      zero_q  <= zero_d;
    end
  end

  always_comb begin
    strb         = '0;
    strb.ir_load = !fault_q && (state_q == S_FETCH);
    strb.rf_we   = !fault_q && (state_q == S_WB) &&
                   dec_reg_write;
    strb.mem_req = in_mem;
    strb.mem_we  = in_mem && dec_mem_write;
    strb.pc_en   = !fault_q && (state_q == S_WB);
    strb.pc_load = strb.pc_en && dec_branch && zero_q;
  end

  assign ir_load     = strb.ir_load;
  assign rf_we       = strb.rf_we;
  assign mem.mem_req = strb.mem_req;
  assign mem.mem_we  = strb.mem_we;
  assign pc_en       = strb.pc_en;
  assign pc_load     = strb.pc_load;
  assign busy        = !fault_q &&
                       (state_q inside {S_FETCH, S_DECODE,
                                        S_EXEC, S_MEM, S_WB});
  assign halted      = (state_q == S_HALT);
  assign fault       = fault_q;
  assign state_o     = state_q;

`ifdef SEQ_PERF_CNT_EN
  logic [CNT_W-1:0] cyc_q, ins_q;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      cyc_q <= '0;
      ins_q <= '0;
    end else begin
      if (busy)  cyc_q <= cyc_q + 1'b1;
      if (pc_en) ins_q <= ins_q + 1'b1;
    end
  end

  assign cycle_cnt = cyc_q;
  assign instr_cnt = ins_q;
`endif

endmodule

// File: tb/tb_core_sequencer.sv
// tb_core_sequencer: directed stimulus with a cycle-tagged
// expectation queue drained by a negedge monitor.
module tb_core_sequencer;
  import core_pkg::*;

  logic       clk = 1'b0;
  logic       reset = 1'b0;
  logic       start = 1'b0, step_mode = 1'b0, step = 1'b0;
  logic       halt_req = 1'b0, fault_clr = 1'b0;
  logic [3:0] opcode = 4'h0;
  logic       dec_reg_write = 1'b0, dec_mem_write = 1'b0;
  logic       dec_load = 1'b0, dec_branch = 1'b0, zero = 1'b0;
  logic       ir_load, rf_we, pc_en, pc_load;
  logic       busy, halted, fault;
  logic [2:0] state_o;
`ifdef SEQ_PERF_CNT_EN
  logic [15:0] cycle_cnt, instr_cnt;
`endif

  core_sequencer_if bus();

  always #5 clk = ~clk;

  core_sequencer dut (
    .clk           (clk),
    .reset         (reset),
    .start         (start),
    .step_mode     (step_mode),
    .step          (step),
    .halt_req      (halt_req),
    .fault_clr     (fault_clr),
    .opcode        (opcode),
    .dec_reg_write (dec_reg_write),
    .dec_mem_write (dec_mem_write),
    .dec_load      (dec_load),
    .dec_branch    (dec_branch),
    .zero          (zero),
    .mem           (bus),
    .ir_load       (ir_load),
    .rf_we         (rf_we),
    .pc_en         (pc_en),
    .pc_load       (pc_load),
    .busy          (busy),
    .halted        (halted),
    .fault         (fault),
`ifdef SEQ_PERF_CNT_EN
    .cycle_cnt     (cycle_cnt),
    .instr_cnt     (instr_cnt),
`endif
    .state_o       (state_o)
  );

  typedef struct {
    int          c;
    string       nm;
    logic [11:0] v;
    bit          pf;
    int          ic;
    int          cc;
  } exp_t;

  exp_t q[$];
  int   cyc = 0;
  int   n_chk = 0;
  int   n_pass = 0;

  always @(posedge clk) cyc <= cyc + 1;

  // {ir_load,rf_we,mem_req,mem_we,pc_en,pc_load,busy,halted,fault,state}
  function automatic logic [11:0] mk(
    input bit il, input bit rw, input bit mr, input bit mw,
    input bit pe, input bit pl, input bit bz, input bit hl,
    input bit ft, input logic [2:0] st);
    return {il, rw, mr, mw, pe, pl, bz, hl, ft, st};
  endfunction

  task automatic ex(input int c, input string nm,
                    input logic [11:0] v);
    exp_t e;
    e.c = c; e.nm = nm; e.v = v;
    e.pf = 1'b0; e.ic = 0; e.cc = 0;
    q.push_back(e);
  endtask

  task automatic tick(input int n = 1);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  always @(negedge clk) begin
    logic [11:0] act;
    act = {ir_load, rf_we, bus.mem_req, bus.mem_we, pc_en,
           pc_load, busy, halted, fault, state_o};
    for (int i = 0; i < q.size(); i++) begin
      if (q[i].c == cyc) begin
        n_chk++;
        if (q[i].pf) begin
`ifdef SEQ_PERF_CNT_EN
          if (int'(instr_cnt) == q[i].ic &&
              int'(cycle_cnt) == q[i].cc) n_pass++;
          else $display("FAIL %s cyc=%0d got ic=%0d cc=%0d want ic=%0d cc=%0d",
                        q[i].nm, cyc, instr_cnt, cycle_cnt,
                        q[i].ic, q[i].cc);
`endif
        end else if (act === q[i].v) begin
          n_pass++;
        end else begin
          $display("FAIL %s cyc=%0d got=%b want=%b",
                   q[i].nm, cyc, act, q[i].v);
        end
        q.delete(i);
        i--;
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog expired at cyc=%0d", cyc);
    $fatal(1, "watchdog");
  end

  initial begin
    int b;
    bus.mem_ready = 1'b0;
    tick(2);
    ex(cyc, "reset", 12'd0);
    reset = 1'b1;

    // store interrupted by reset while waiting in MEM
    b = cyc;
    opcode = 4'h2; dec_mem_write = 1'b1; start = 1'b1;
    ex(b + 4, "st_mem", mk(0,0,1,1,0,0,1,0,0,3'd4));
    ex(b + 5, "rst_async", 12'd0);
    ex(b + 6, "rst_idle", 12'd0);
    ex(b + 7, "rst_idle2", 12'd0);
    tick(); start = 1'b0;
    tick(4); reset = 1'b0;
    tick(); reset = 1'b1;
    tick();
    dec_mem_write = 1'b0;

    // ALU op, then a HALT opcode
    b = cyc;
    opcode = 4'h1; dec_reg_write = 1'b1; start = 1'b1;
    ex(b + 1, "alu_fetch", mk(1,0,0,0,0,0,1,0,0,3'd1));
    ex(b + 2, "alu_dec",   mk(0,0,0,0,0,0,1,0,0,3'd2));
    ex(b + 3, "alu_exec",  mk(0,0,0,0,0,0,1,0,0,3'd3));
    ex(b + 4, "alu_wb",    mk(0,1,0,0,1,0,1,0,0,3'd5));
    ex(b + 5, "alu_fetch2",mk(1,0,0,0,0,0,1,0,0,3'd1));
    ex(b + 6, "hlt_dec",   mk(0,0,0,0,0,0,1,0,0,3'd2));
    ex(b + 7, "hlt_halt",  mk(0,0,0,0,0,0,0,1,0,3'd7));
    ex(b + 8, "hlt_hold",  mk(0,0,0,0,0,0,0,1,0,3'd7));
    tick(); start = 1'b0;
    tick(4); opcode = 4'hF; dec_reg_write = 1'b0;
    tick(3);

    // branch taken via zero_q, then not taken; halt_req at WB
    b = cyc;
    opcode = 4'h3; dec_branch = 1'b1; zero = 1'b1; start = 1'b1;
    ex(b + 1, "br_fetch",  mk(1,0,0,0,0,0,1,0,0,3'd1));
    ex(b + 4, "br_taken",  mk(0,0,0,0,1,1,1,0,0,3'd5));
    ex(b + 5, "br_fetch2", mk(1,0,0,0,0,0,1,0,0,3'd1));
    ex(b + 8, "br_not",    mk(0,0,0,0,1,0,1,0,0,3'd5));
    ex(b + 9, "hreq_halt", mk(0,0,0,0,0,0,0,1,0,3'd7));
    tick(); start = 1'b0;
    tick(3); zero = 1'b0;
    tick(3); halt_req = 1'b1;
    tick(2); halt_req = 1'b0; dec_branch = 1'b0;

    // store with 3 wait cycles, then load that times out
    b = cyc;
    opcode = 4'h2; dec_mem_write = 1'b1; start = 1'b1;
    ex(b + 4,  "st_w0",   mk(0,0,1,1,0,0,1,0,0,3'd4));
    ex(b + 5,  "st_w1",   mk(0,0,1,1,0,0,1,0,0,3'd4));
    ex(b + 6,  "st_w2",   mk(0,0,1,1,0,0,1,0,0,3'd4));
    ex(b + 7,  "st_wb",   mk(0,0,0,0,1,0,1,0,0,3'd5));
    ex(b + 8,  "st_next", mk(1,0,0,0,0,0,1,0,0,3'd1));
    ex(b + 11, "ld_m0",   mk(0,0,1,0,0,0,1,0,0,3'd4));
    ex(b + 18, "ld_m7",   mk(0,0,1,0,0,0,1,0,0,3'd4));
    ex(b + 19, "fault",   mk(0,0,0,0,0,0,0,0,1,3'd0));
    ex(b + 20, "fault_st",mk(0,0,0,0,0,0,0,0,1,3'd0));
    ex(b + 21, "fault_clr", 12'd0);
    tick(); start = 1'b0;
    tick(5); bus.mem_ready = 1'b1;
    tick(); bus.mem_ready = 1'b0;
    tick(); dec_mem_write = 1'b0; dec_load = 1'b1;
    dec_reg_write = 1'b1;
    tick(11); start = 1'b1;
    tick(); start = 1'b0; fault_clr = 1'b1;
    tick(); fault_clr = 1'b0;

    // single-step mode
    b = cyc;
    opcode = 4'h1; dec_load = 1'b0; step_mode = 1'b1;
    start = 1'b1;
    ex(b + 4,  "ss_wb",    mk(0,1,0,0,1,0,1,0,0,3'd5));
    ex(b + 5,  "ss_pause", mk(0,0,0,0,0,0,0,0,0,3'd6));
    ex(b + 6,  "ss_hold",  mk(0,0,0,0,0,0,0,0,0,3'd6));
    ex(b + 7,  "ss_step",  mk(1,0,0,0,0,0,1,0,0,3'd1));
    ex(b + 10, "ss_wb2",   mk(0,1,0,0,1,0,1,0,0,3'd5));
    ex(b + 11, "ss_pause2",mk(0,0,0,0,0,0,0,0,0,3'd6));
    ex(b + 12, "ss_hwins", mk(0,0,0,0,0,0,0,1,0,3'd7));
    tick(); start = 1'b0;
    tick(5); step = 1'b1;
    tick(); step = 1'b0;
    tick(4); halt_req = 1'b1; step = 1'b1;
    tick(); halt_req = 1'b0; step = 1'b0; step_mode = 1'b0;

    // mem_ready arriving on the timeout cycle wins
    b = cyc;
    opcode = 4'h4; dec_load = 1'b1; start = 1'b1;
    ex(b + 4,  "tie_m0",  mk(0,0,1,0,0,0,1,0,0,3'd4));
    ex(b + 11, "tie_m7",  mk(0,0,1,0,0,0,1,0,0,3'd4));
    ex(b + 12, "tie_wb",  mk(0,1,0,0,1,0,1,0,0,3'd5));
    ex(b + 13, "tie_fet", mk(1,0,0,0,0,0,1,0,0,3'd1));
    ex(b + 15, "tie_halt",mk(0,0,0,0,0,0,0,1,0,3'd7));
    tick(); start = 1'b0;
    tick(10); bus.mem_ready = 1'b1;
    tick(); bus.mem_ready = 1'b0; dec_load = 1'b0;
    opcode = 4'hF;
    tick(3);

`ifdef SEQ_PERF_CNT_EN
    reset = 1'b0;
    tick();
    reset = 1'b1;
    b = cyc;
    opcode = 4'h1; dec_reg_write = 1'b1; start = 1'b1;
    ex(b + 13, "pf_halt", mk(0,0,0,0,0,0,0,1,0,3'd7));
    begin
      exp_t e;
      e.c = b + 13; e.nm = "perf_cnt"; e.v = '0;
      e.pf = 1'b1; e.ic = 3; e.cc = 12;
      q.push_back(e);
    end
    tick(); start = 1'b0;
    tick(10); halt_req = 1'b1;
    tick(2); halt_req = 1'b0;
`endif

    tick(2);
    foreach (q[i]) begin
      n_chk++;
      $display("FAIL %s never sampled (cyc %0d)", q[i].nm, q[i].c);
    end
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule

// File: doc/core_sequencer.md
Name: core_sequencer

Overview:
- Multi-cycle control FSM for the 8-bit core: sequences fetch, decode, execute, memory and writeback over the shared PC/ROM/register-file/ALU/RAM datapath.
- Consumes decoder control fields and the ALU zero flag; produces one-cycle enables for the PC, instruction register, register file and data RAM.
- Adds RAM ready handshake with timeout, halt, single-step and fault reporting.

Parameters:
- HALT_OPCODE, 4'hF, opcode that stops the sequencer.
- MEM_TIMEOUT, 8, max cycles to wait for mem_ready before fault (1..2^TO_W-1).
- TO_W, 4, width of wait counter.
- CNT_W, 16, width of performance counters (optional feature).

Ports:
- clk  in  1  system clock, rising edge.
- reset  in  1  asynchronous, active-low reset.
- start  in  1  leave IDLE/HALT and begin fetching.
- step_mode  in  1  1 = pause after every instruction.
- step  in  1  one-cycle pulse: release PAUSE.
- halt_req  in  1  external halt, honoured at instruction boundary.
- fault_clr  in  1  leave FAULT to IDLE.
- opcode  in  4  instruction[15:12].
- dec_reg_write  in  1  decoder reg_write.
- dec_mem_write  in  1  decoder mem_write.
- dec_load  in  1  decoder c_data (RAM to register).
- dec_branch  in  1  decoder c_cond.
- zero  in  1  ALU zero flag.
- mem_ready  in  1  RAM access complete.
- ir_load  out  1  latch instruction.
- rf_we  out  1  register-file write strobe.
- mem_req  out  1  RAM access request.
- mem_we  out  1  RAM write enable.
- pc_en  out  1  advance PC.
- pc_load  out  1  take branch (pc_jump).
- busy  out  1  not in IDLE/HALT/PAUSE/FAULT.
- halted  out  1  in HALT.
- fault  out  1  in FAULT.
- state_o  out  3  current state encoding.

Behaviour:
- Reset (reset=0, async): state IDLE; all outputs 0; wait counter 0; zero_q 0.
- States:
  - IDLE(0): start=1 goes to FETCH.
  - FETCH(1): ir_load=1; next DECODE.
  - DECODE(2): opcode==HALT_OPCODE goes to HALT, else EXEC.
  - EXEC(3): zero_q<=zero; dec_mem_write|dec_load goes to MEM, else WB.
  - MEM(4): mem_req=1; mem_we=dec_mem_write; wait counter increments each cycle.
    - mem_ready=1: next WB; counter cleared.
    - Counter==MEM_TIMEOUT-1 with mem_ready=0: next FAULT.
    - mem_ready on the timeout cycle wins (goes to WB).
  - WB(5): rf_we=dec_reg_write; pc_en=1; pc_load=dec_branch&zero_q. Next state priority: halt_req goes to HALT; else step_mode goes to PAUSE; else FETCH.
  - PAUSE(6): step=1 goes to FETCH; halt_req goes to HALT (halt_req wins over step).
  - HALT(7): halted=1; start=1 clears halted and goes to FETCH.
  - FAULT: encoded via fault flag with state_o=0. fault=1 sticky; all strobes 0; fault_clr goes to IDLE.
- All strobes are Moore outputs of the state register; each strobe lasts exactly one cycle, except mem_req/mem_we, which hold for all of MEM.
- Latency:
  - ALU/branch instruction: 4 cycles FETCH to FETCH.
  - Load/store: 5 + wait cycles.
- pc_en and pc_load assert in the same cycle; the PC takes pc_jump when pc_load=1, else PC+1.
- HALT opcode: no rf_we, no pc_en; PC stays on the halt instruction.
- halt_req in any other state is ignored until WB/PAUSE (level sampled there).
- start while busy: ignored.
- Mid-operation reset clears everything immediately, including a MEM access in progress; no partial write completes after reset.

Optional Feature:
- SEQ_PERF_CNT_EN defined: adds outputs cycle_cnt[CNT_W-1:0] (increments every cycle busy=1) and instr_cnt[CNT_W-1:0] (increments on each WB). Both wrap at 2^CNT_W, clear on reset, and hold in FAULT.
- Not defined: ports and counters absent; all other behaviour identical.

Decomposition:
- Shared package core_pkg: state localparams (S_IDLE..S_HALT, 3-bit), opcode width 4, HALT_OPCODE default, strobe-bundle struct if used.
- One sub-module: seq_wait_timer (TO_W counter with clear/enable/expired) used by MEM.
- FSM and output decode stay in core_sequencer.

Test Plan:
- Reset mid-MEM (store, mem_ready=0) -> all outputs 0 same cycle reset falls; state_o=0 after release.
- start, ALU op 4'h1, dec_reg_write=1 -> ir_load@c1, rf_we+pc_en@c4, ir_load again@c5.
- Branch dec_branch=1, zero=1 in EXEC then zero=0 in WB -> pc_load=1 (zero_q used); with zero=0 in EXEC -> pc_load=0, pc_en=1.
- Store, mem_ready after 3 cycles -> mem_req=mem_we=1 for exactly 3 cycles, then WB; with mem_ready never -> fault=1 after 8 MEM cycles, fault_clr -> IDLE.
- step_mode=1 -> PAUSE after WB, busy=0; step pulse -> FETCH next cycle; halt_req+step same cycle -> HALT.
- opcode 4'hF -> halted=1, no pc_en/rf_we; start -> FETCH. With SEQ_PERF_CNT_EN: 3 ALU ops -> instr_cnt=3, cycle_cnt=12.
